// File: rtl/alu_issue_ctrl_if.sv
// Request, response and ALU-drive bundle for alu_issue_ctrl.
// The master side is the decode/execute stage together with the ALU.
// The slave side is the issue controller.
interface alu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_kind;
   logic [3:0]  req_op;
   logic [1:0]  req_sign;
   logic [2:0]  req_cmp;
   logic [31:0] req_a;
   logic [31:0] req_b;

   logic [3:0]  alu_op;
   logic [1:0]  alu_sign;
   logic [2:0]  alu_cmp;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic [31:0] alu_hi;
   logic [31:0] alu_lo;
   logic [3:0]  alu_flags;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_flags;
   logic        rsp_err;

   modport master (
      output req_valid, req_kind, req_op, req_sign, req_cmp, req_a, req_b,
      input  req_ready,
      input  alu_op, alu_sign, alu_cmp, alu_a, alu_b,
      output alu_y, alu_hi, alu_lo, alu_flags,
      input  rsp_valid, rsp_data, rsp_flags, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_kind, req_op, req_sign, req_cmp, req_a, req_b,
      output req_ready,
      output alu_op, alu_sign, alu_cmp, alu_a, alu_b,
      input  alu_y, alu_hi, alu_lo, alu_flags,
      output rsp_valid, rsp_data, rsp_flags, rsp_err,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller around the combinational ALU.
// Each accepted operation is run to completion before the next is taken.
// The controller also owns the architectural HI/LO pair.
module alu_issue_ctrl #(
   parameter int ALU_LAT    = 1,
   parameter int MULDIV_LAT = 4
) (
   input  logic            clk,
   input  logic            reset,
   alu_issue_ctrl_if.slave bus,
   output logic [31:0]     hi_q,
   output logic [31:0]     lo_q
);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   localparam logic [1:0] KIND_ALU  = 2'b00;
   localparam logic [1:0] KIND_MFHI = 2'b01;
   localparam logic [1:0] KIND_MFLO = 2'b10;
   localparam logic [3:0] OP_ADD    = 4'b0001;
   localparam logic [3:0] OP_MULT   = 4'b0010;
   localparam logic [3:0] OP_DIV    = 4'b0011;

   state_t      r_state;
   logic [15:0] r_count;
   logic [1:0]  r_kind;
   logic [31:0] r_opA;
   logic [31:0] r_opB;
   logic [3:0]  r_aluOp;
   logic [1:0]  r_aluSign;
   logic [2:0]  r_aluCmp;
   logic [31:0] r_aluA;
   logic [31:0] r_aluB;
   logic        r_rspValid;
   logic [31:0] r_rspData;
   logic [3:0]  r_rspFlags;
   logic        r_rspErr;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_accept;
   logic        w_isMulDiv;

   assign w_accept   = (r_state == IDLE) && bus.req_valid;
   assign w_isMulDiv = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);

   assign bus.req_ready = (r_state == IDLE) && !reset;
   assign bus.alu_op    = r_aluOp;
   assign bus.alu_sign  = r_aluSign;
   assign bus.alu_cmp   = r_aluCmp;
   assign bus.alu_a     = r_aluA;
   assign bus.alu_b     = r_aluB;
   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_data  = r_rspData;
   assign bus.rsp_flags = r_rspFlags;
   assign bus.rsp_err   = r_rspErr;
   assign hi_q          = r_hi;
   assign lo_q          = r_lo;

   // Control FSM: accept a request, let the ALU settle, collect the result and hold the response until it is taken.
   // The settle counter is loaded with the latency and the ALU is sampled once it has counted down to zero, so the
   // registered ALU inputs see a full latency of cycles after their own load edge. MF/MT kinds load zero and pass
   // through DRIVE for one cycle, which gives them their single cycle of response latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_kind     <= '0;
         r_opA      <= '0;
         r_opB      <= '0;
         r_aluOp    <= '0;
         r_aluSign  <= '0;
         r_aluCmp   <= '0;
         r_aluA     <= '0;
         r_aluB     <= '0;
         r_rspValid <= 1'b0;
         r_rspData  <= '0;
         r_rspFlags <= '0;
         r_rspErr   <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_kind  <= bus.req_kind;
                  r_opA   <= bus.req_a;
                  r_opB   <= bus.req_b;
                  r_state <= DRIVE;
                  if (bus.req_kind == KIND_ALU) begin
                     r_aluOp   <= bus.req_op;
                     r_aluSign <= bus.req_sign;
                     r_aluCmp  <= bus.req_cmp;
                     r_aluA    <= bus.req_a;
                     r_aluB    <= bus.req_b;
                     r_count   <= w_isMulDiv ? 16'(MULDIV_LAT) : 16'(ALU_LAT);
                  end else begin
                     r_count <= '0;
                  end
               end
            end
            DRIVE: begin
               if (r_count != 16'd0) begin
                  r_count <= r_count - 16'd1;
               end else begin
                  r_state    <= RESP;
                  r_rspValid <= 1'b1;
                  r_rspData  <= '0;
                  r_rspFlags <= '0;
                  r_rspErr   <= 1'b0;
                  case (r_kind)
                     KIND_ALU: begin
                        if (r_aluOp == OP_MULT) begin
                           r_hi <= bus.alu_hi;
                           r_lo <= bus.alu_lo;
                        end else if (r_aluOp == OP_DIV) begin
                           if (r_aluB != 32'd0) begin
                              r_hi <= bus.alu_hi;
                              r_lo <= bus.alu_lo;
                           end else begin
                              r_rspErr <= 1'b1;
                           end
                        end else if (r_aluOp == OP_ADD) begin
                           r_rspData  <= bus.alu_y;
                           r_rspFlags <= bus.alu_flags;
                        end else begin
                           r_rspData <= bus.alu_y;
                        end
                     end
                     KIND_MFHI: r_rspData <= r_hi;
                     KIND_MFLO: r_rspData <= r_lo;
                     default: begin
                        r_hi <= r_opA;
                        r_lo <= r_opB;
                     end
                  endcase
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_rspErr   <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  flags;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] hiQ;
   logic [31:0] loQ;
   int          cycle = 0;
   int          acceptCycle = 0;
   int          hsCycle = 0;
   int          nAsserts = 0;
   int          nFail = 0;
   exp_t        sbQ[$];

   logic [32:0] aluSum;
   logic [63:0] aluProd;

   alu_issue_ctrl_if bus();

   alu_issue_ctrl #(.ALU_LAT(1), .MULDIV_LAT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .hi_q  (hiQ),
      .lo_q  (loQ)
   );

   // Free-running clock and cycle counter used for latency measurement
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Behavioural ALU: flags always reflect the add/sub path so non-add ops present nonzero flags
   always_comb begin
      aluSum  = bus.alu_sign[0] ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
      aluProd = {32'd0, bus.alu_a} * {32'd0, bus.alu_b};
      bus.alu_flags[0] = bus.alu_sign[0]
                       ? ((bus.alu_a[31] != bus.alu_b[31]) && (aluSum[31] != bus.alu_a[31]))
                       : ((bus.alu_a[31] == bus.alu_b[31]) && (aluSum[31] != bus.alu_a[31]));
      bus.alu_flags[1] = aluSum[31];
      bus.alu_flags[2] = (aluSum[31:0] == 32'd0);
      bus.alu_flags[3] = aluSum[32];
      bus.alu_hi = 32'hA5A5A5A5;
      bus.alu_lo = 32'h5A5A5A5A;
      case (bus.alu_op)
         4'b0000: bus.alu_y = bus.alu_a & bus.alu_b;
         4'b0001: bus.alu_y = aluSum[31:0];
         4'b0010: begin
            bus.alu_y  = aluProd[31:0];
            bus.alu_hi = aluProd[63:32];
            bus.alu_lo = aluProd[31:0];
         end
         4'b0011: begin
            bus.alu_y = 32'd0;
            if (bus.alu_b != 32'd0) begin
               bus.alu_hi = bus.alu_a % bus.alu_b;
               bus.alu_lo = bus.alu_a / bus.alu_b;
            end else begin
               bus.alu_hi = 32'hFFFFFFFF;
               bus.alu_lo = 32'hFFFFFFFF;
            end
         end
         4'b0100: bus.alu_y = bus.alu_a | bus.alu_b;
         default: bus.alu_y = bus.alu_a ^ bus.alu_b;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic driveReq(input logic [1:0] kind, input logic [3:0] op, input logic [1:0] sign,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expData, input logic [3:0] expFlags,
                           input logic expErr, input int lat);
      exp_t e;
      bus.req_kind  = kind;
      bus.req_op    = op;
      bus.req_sign  = sign;
      bus.req_cmp   = 3'b101;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_valid = 1'b1;
      e.data  = expData;
      e.flags = expFlags;
      e.err   = expErr;
      e.lat   = lat;
      sbQ.push_back(e);
   endtask

   task automatic waitAccept(input string tag);
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checkVal({tag, "_ready_before_accept"}, {31'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 1'b0;
      acceptCycle = cycle;
   endtask

   task automatic applyStimulus(input string tag, input logic [1:0] kind, input logic [3:0] op,
                                input logic [1:0] sign, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expData, input logic [3:0] expFlags,
                                input logic expErr, input int lat);
      driveReq(kind, op, sign, a, b, expData, expFlags, expErr, lat);
      waitAccept(tag);
   endtask

   task automatic checkOutput(input string tag, input int holdCycles);
      exp_t e;
      int   n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checkVal({tag, "_sb_nonempty"}, {31'd0, (sbQ.size() > 0)}, 32'd1);
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         checkVal({tag, "_latency"}, cycle - acceptCycle, e.lat);
         checkVal({tag, "_data"}, bus.rsp_data, e.data);
         checkVal({tag, "_flags"}, {28'd0, bus.rsp_flags}, {28'd0, e.flags});
         checkVal({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
         for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkVal({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            checkVal({tag, "_hold_data"}, bus.rsp_data, e.data);
            checkVal({tag, "_hold_flags"}, {28'd0, bus.rsp_flags}, {28'd0, e.flags});
            checkVal({tag, "_hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
         end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      hsCycle = cycle;
      checkVal({tag, "_valid_dropped"}, {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   // Directed sequence
   initial begin
      bit sawValid;
      bus.req_valid = 1'b0;
      bus.req_kind  = 2'b00;
      bus.req_op    = 4'b0000;
      bus.req_sign  = 2'b00;
      bus.req_cmp   = 3'b000;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.rsp_ready = 1'b0;

      tick();
      tick();
      checkVal("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkVal("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      checkVal("reset_hi", hiQ, 32'd0);
      checkVal("reset_lo", loQ, 32'd0);
      checkVal("reset_alu_a", bus.alu_a, 32'd0);
      checkVal("reset_rsp_data", bus.rsp_data, 32'd0);
      reset = 1'b0;
      #1;
      checkVal("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // Signed add overflow: flags forwarded
      applyStimulus("add", 2'b00, 4'b0001, 2'b10, 32'h7FFFFFFF, 32'h00000001,
                    32'h80000000, 4'b0011, 1'b0, 2);
      checkVal("add_alu_op", {28'd0, bus.alu_op}, 32'd1);
      checkVal("add_alu_sign", {30'd0, bus.alu_sign}, 32'd2);
      checkVal("add_alu_cmp", {29'd0, bus.alu_cmp}, 32'd5);
      checkVal("add_alu_a", bus.alu_a, 32'h7FFFFFFF);
      checkOutput("add", 0);

      // Multiply: HI/LO loaded, operands held through the settle window
      applyStimulus("mult", 2'b00, 4'b0010, 2'b00, 32'h00010000, 32'h00010000,
                    32'd0, 4'd0, 1'b0, 5);
      for (int i = 0; i < 4; i++) begin
         checkVal("mult_hold_a", bus.alu_a, 32'h00010000);
         checkVal("mult_no_early_rsp", {31'd0, bus.rsp_valid}, 32'd0);
         tick();
      end
      checkOutput("mult", 0);
      checkVal("mult_hi", hiQ, 32'h00000001);
      checkVal("mult_lo", loQ, 32'h00000000);

      applyStimulus("mfhi", 2'b01, 4'b0000, 2'b00, 32'd0, 32'd0, 32'h00000001, 4'd0, 1'b0, 1);
      checkOutput("mfhi", 0);
      applyStimulus("mflo", 2'b10, 4'b0000, 2'b00, 32'd0, 32'd0, 32'h00000000, 4'd0, 1'b0, 1);
      checkOutput("mflo", 0);

      // Divide by zero: error flagged, HI/LO untouched
      applyStimulus("divz", 2'b00, 4'b0011, 2'b00, 32'd100, 32'd0, 32'd0, 4'd0, 1'b1, 5);
      checkOutput("divz", 0);
      checkVal("divz_hi", hiQ, 32'h00000001);
      checkVal("divz_lo", loQ, 32'h00000000);

      // AND under backpressure with the next request (MTHILO) already waiting
      applyStimulus("and", 2'b00, 4'b0000, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00,
                    32'hF000F000, 4'd0, 1'b0, 2);
      driveReq(2'b11, 4'b0000, 2'b00, 32'hDEADBEEF, 32'h12345678, 32'd0, 4'd0, 1'b0, 1);
      checkOutput("and", 5);
      checkVal("post_hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
      waitAccept("mthilo");
      checkVal("mthilo_accept_gap", acceptCycle - hsCycle, 32'd1);
      checkOutput("mthilo", 0);
      checkVal("mthilo_hi", hiQ, 32'hDEADBEEF);
      checkVal("mthilo_lo", loQ, 32'h12345678);

      applyStimulus("mflo2", 2'b10, 4'b0000, 2'b00, 32'd0, 32'd0, 32'h12345678, 4'd0, 1'b0, 1);
      checkOutput("mflo2", 0);

      // Reset in the middle of a multiply drops it and clears HI/LO
      applyStimulus("mult_rst", 2'b00, 4'b0010, 2'b00, 32'd3, 32'd5, 32'd0, 4'd0, 1'b0, 5);
      tick();
      tick();
      reset = 1'b1;
      tick();
      sbQ.delete();
      checkVal("rst_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
      checkVal("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      checkVal("rst_hi", hiQ, 32'd0);
      checkVal("rst_lo", loQ, 32'd0);
      reset = 1'b0;
      #1;
      checkVal("rst_release_ready", {31'd0, bus.req_ready}, 32'd1);
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.rsp_valid === 1'b1) sawValid = 1'b1;
      end
      checkVal("rst_no_rsp", {31'd0, sawValid}, 32'd0);
      checkVal("rst_idle_ready", {31'd0, bus.req_ready}, 32'd1);

      applyStimulus("mfhi_rst", 2'b01, 4'b0000, 2'b00, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1);
      checkOutput("mfhi_rst", 0);

      // Unsigned subtract with borrow: flags forwarded, error cleared
      applyStimulus("sub", 2'b00, 4'b0001, 2'b01, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b1010, 1'b0, 2);
      checkOutput("sub", 0);

      // Opcode 1111 forwarded unchecked, flags suppressed
      applyStimulus("op15", 2'b00, 4'b1111, 2'b00, 32'h0F0F0000, 32'h00FF00FF,
                    32'h0FF000FF, 4'd0, 1'b0, 2);
      checkVal("op15_alu_op", {28'd0, bus.alu_op}, 32'd15);
      checkOutput("op15", 0);
      checkVal("op15_alu_op_retained", {28'd0, bus.alu_op}, 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
